sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the write-buffer depth in entries (power of 2, at least 2).
REQ-002 Parameter STARVE_LIMIT, default 8, SHALL set the consecutive read grants allowed while the write buffer is non-empty.
REQ-003 Clk  in  1  SHALL be the single 50 MHz clock; all state updates on its rising edge.
REQ-004 Reset  in  1  SHALL be the synchronous, active-high reset.
REQ-005 wr_valid  in  1  SHALL indicate a camera pixel write request this cycle.
REQ-006 wr_addr  in  20  SHALL give the SRAM word address of the camera write.
REQ-007 wr_data  in  16  SHALL give the RGB565 pixel to write.
REQ-008 wr_ready  out  1  SHALL indicate that the write buffer accepts a push this cycle.
REQ-009 rd_req  in  1  SHALL indicate a VGA read request this cycle.
REQ-010 rd_addr  in  20  SHALL give the SRAM word address to read.
REQ-011 rd_ready  out  1  SHALL indicate that the read request is granted this cycle.
REQ-012 rd_data  out  16  SHALL carry the returned read data.
REQ-013 rd_valid  out  1  SHALL qualify rd_data for one cycle per completed read.
REQ-014 mem_address  out  20  SHALL be the SRAM controller word address.
REQ-015 mem_read  out  1  SHALL be the SRAM controller read strobe.
REQ-016 mem_write  out  1  SHALL be the SRAM controller write strobe.
REQ-017 mem_writedata  out  16  SHALL be the SRAM controller write data.
REQ-018 mem_readdata  in  16  SHALL be the SRAM controller read data.
REQ-019 mem_readdatavalid  in  1  SHALL qualify mem_readdata.
REQ-020 fifo_level  out  log2(FIFO_DEPTH)+1  SHALL report the current write-buffer occupancy.
REQ-021 drop_cnt  out  8  SHALL count camera writes dropped because the buffer was full.

Function
REQ-022 The write buffer SHALL be a FIFO holding {wr_addr, wr_data}, and wr_ready SHALL equal !full, with no same-cycle pop bypass.
REQ-023 A push SHALL occur when wr_valid && wr_ready.
REQ-024 When wr_valid && !wr_ready, the write SHALL be discarded and drop_cnt SHALL increment, saturating at 255.
REQ-025 Arbitration SHALL be combinational each cycle and select READ, WRITE or IDLE.
REQ-026 READ SHALL be selected when rd_req && !(fifo non-empty && starve_cnt == STARVE_LIMIT).
REQ-027 WRITE SHALL be selected when the FIFO is non-empty and READ is not selected.
REQ-028 IDLE SHALL be selected otherwise.
REQ-029 rd_ready SHALL be high exactly when READ is selected.
REQ-030 The VGA requester SHALL hold rd_req and rd_addr until rd_ready is high.
REQ-031 Commands SHALL be registered: a grant in cycle N drives mem_read or mem_write high for exactly cycle N+1, with the matching mem_address and mem_writedata.
REQ-032 When no command is granted, mem_read, mem_write, mem_address and mem_writedata SHALL all be 0.
REQ-033 A WRITE grant SHALL pop the FIFO head in the same cycle.
REQ-034 A push and a pop in the same cycle SHALL leave fifo_level unchanged.
REQ-035 starve_cnt SHALL increment on each READ grant while the FIFO is non-empty.
REQ-036 starve_cnt SHALL clear on any WRITE grant or whenever the FIFO is empty, and SHALL never exceed STARVE_LIMIT.
REQ-037 outstanding SHALL be a 3-bit count of issued, unreturned reads: +1 on each cycle with mem_read high, -1 on each mem_readdatavalid, and both together leave it unchanged.
REQ-038 rd_data/rd_valid SHALL be registered copies of mem_readdata/mem_readdatavalid, delayed one cycle.
REQ-039 rd_valid SHALL assert only if outstanding != 0 at the return.
REQ-040 A return that arrives with outstanding == 0 SHALL be ignored.
REQ-041 Read data SHALL return in issue order; the arbiter SHALL NOT reorder reads.
REQ-042 Reads SHALL never be granted while outstanding == 7.
REQ-043 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and full/empty SHALL be distinguished by fifo_level.

Reset
REQ-044 While Reset is high at a clock edge, all of the following SHALL be 0 on the next cycle: FIFO contents and pointers, fifo_level, drop_cnt, starve_cnt, outstanding, mem_read, mem_write, mem_address, mem_writedata, rd_data and rd_valid.
REQ-045 wr_ready SHALL be 1 on the cycle after Reset deasserts.
REQ-046 A Reset asserted mid-operation SHALL abandon any in-flight command.
REQ-047 Read returns after a mid-operation Reset SHALL be dropped per REQ-040.

Verification
REQ-048 The bench SHALL check that wr_valid=1 with addr 0x00010 and data 0xF800 for 1 cycle, with rd_req=0, gives mem_write=1, mem_address=0x00010, mem_writedata=0xF800 two cycles later, and fifo_level returns to 0.
REQ-049 The bench SHALL check that rd_req held 1 with addr 0x12C00 and memory data 0xABCD returned 2 cycles after mem_read gives rd_valid=1 and rd_data=0xABCD 3 cycles after mem_read.
REQ-050 The bench SHALL check that with rd_req held 1 and 1 write buffered, exactly 8 reads are issued, then 1 write, then reads resume, and rd_ready=0 on the write-grant cycle.
REQ-051 The bench SHALL check that 6 back-to-back camera writes with rd_req=1 throughout give wr_ready=0 once fifo_level=4 and a drop_cnt increment per rejected write; after 300 rejects, drop_cnt=255.
REQ-052 The bench SHALL check that Reset pulsed 1 cycle with 2 reads outstanding and FIFO=3 gives zero outputs and fifo_level=0, and the two late mem_readdatavalid pulses produce no rd_valid.
REQ-053 The bench SHALL check that a simultaneous push and WRITE grant at fifo_level=4 holds fifo_level at 4 and leaves drop_cnt unchanged.

Source files
------------

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller between buffered camera writes and VGA reads.
// Reads win by default; a bounded starvation counter guarantees the write buffer drains.
module sram_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_valid,
  input  logic [19:0]                 wr_addr,
  input  logic [15:0]                 wr_data,
  output logic                        wr_ready,
  input  logic                        rd_req,
  input  logic [19:0]                 rd_addr,
  output logic                        rd_ready,
  output logic [15:0]                 rd_data,
  output logic                        rd_valid,
  output logic [19:0]                 mem_address,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [15:0]                 mem_writedata,
  input  logic [15:0]                 mem_readdata,
  input  logic                        mem_readdatavalid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [19:0] addr;
    logic [15:0] data;
  } wr_entry_t;

  wr_entry_t     fifo_q [FIFO_DEPTH];
  wr_entry_t     fifo_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    drop_q, drop_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [2:0]    outstanding_q, outstanding_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [19:0]   mem_address_q, mem_address_d;
  logic [15:0]   mem_writedata_q, mem_writedata_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;

  logic          full, empty, push, starved, rd_block, rd_sel, wr_sel, ret_ok;
  wr_entry_t     head;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    full    = (level_q == LEVEL_FULL);
    empty   = (level_q == '0);
    head    = fifo_q[rd_ptr_q];
    push    = wr_valid && !full;
    starved = !empty && (starve_q == STARVE_MAX);
    // A read still on the bus is not yet in outstanding_q; count it so the 3-bit counter cannot wrap.
    rd_block = (outstanding_q == 3'd7) || ((outstanding_q == 3'd6) && mem_read_q);
    rd_sel  = rd_req && !starved && !rd_block;
    wr_sel  = !empty && !rd_sel;
    ret_ok  = mem_readdatavalid && (outstanding_q != 3'd0);

    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = '{addr: wr_addr, data: wr_data};
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(wr_sel);
    level_d  = level_q + LW'(push) - LW'(wr_sel);

    drop_d = drop_q;
    if (wr_valid && full && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    starve_d = starve_q;
    if (empty || wr_sel)                        starve_d = '0;
    else if (rd_sel && (starve_q != STARVE_MAX)) starve_d = starve_q + SW'(1);

    mem_read_d      = rd_sel;
    mem_write_d     = wr_sel;
    mem_address_d   = rd_sel ? rd_addr : (wr_sel ? head.addr : 20'd0);
    mem_writedata_d = wr_sel ? head.data : 16'd0;

    outstanding_d = outstanding_q;
    if (mem_read_q && !ret_ok)      outstanding_d = outstanding_q + 3'd1;
    else if (!mem_read_q && ret_ok) outstanding_d = outstanding_q - 3'd1;

    rd_valid_d = ret_ok;
    rd_data_d  = mem_readdata;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the buffer array is cleared too, so no stale pixel survives a reset.
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      drop_q          <= '0;
      starve_q        <= '0;
      outstanding_q   <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      rd_data_q       <= '0;
      rd_valid_q      <= 1'b0;
    end else begin
      fifo_q          <= fifo_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      drop_q          <= drop_d;
      starve_q        <= starve_d;
      outstanding_q   <= outstanding_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      rd_data_q       <= rd_data_d;
      rd_valid_q      <= rd_valid_d;
    end
  end

  assign wr_ready      = !full;
  assign rd_ready      = rd_sel;
  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign mem_address   = mem_address_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_writedata = mem_writedata_q;
  assign fifo_level    = level_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a 4-deep instance with a 2-cycle SRAM read model,
// plus an 8-deep instance for the push-while-popping case at level 4.
module tb_sram_arbiter;

  logic        clk;
  logic        reset;
  logic        wr_valid, rd_req, mem_readdatavalid;
  logic [19:0] wr_addr, rd_addr;
  logic [15:0] wr_data, mem_rdata;
  logic        wr_ready, rd_ready, rd_valid, mem_read, mem_write;
  logic [15:0] rd_data, mem_writedata;
  logic [19:0] mem_address;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_cnt;

  logic        wr_valid8, rd_req8;
  logic        wr_ready8, rd_ready8, rd_valid8, mem_read8, mem_write8;
  logic [15:0] rd_data8, mem_writedata8;
  logic [19:0] mem_address8;
  logic [3:0]  fifo_level8;
  logic [7:0]  drop_cnt8;

  int n_tests = 0;
  int n_fail  = 0;

  sram_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) u_dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_rdata),
    .mem_readdatavalid(mem_readdatavalid),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  sram_arbiter #(.FIFO_DEPTH(8), .STARVE_LIMIT(8)) u_dut8 (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid8), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready8),
    .rd_req(rd_req8), .rd_addr(rd_addr), .rd_ready(rd_ready8),
    .rd_data(rd_data8), .rd_valid(rd_valid8),
    .mem_address(mem_address8), .mem_read(mem_read8), .mem_write(mem_write8),
    .mem_writedata(mem_writedata8), .mem_readdata(mem_rdata),
    .mem_readdatavalid(1'b0),
    .fifo_level(fifo_level8), .drop_cnt(drop_cnt8)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // SRAM model: a read strobed in cycle k returns in cycle k+2.
  initial begin
    logic p0, p1;
    p0 = 1'b0;
    p1 = 1'b0;
    mem_readdatavalid = 1'b0;
    forever begin
      @(negedge clk);
      mem_readdatavalid = p1;
      p1 = p0;
      p0 = mem_read;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    wr_valid = 1'b0; rd_req = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    wr_valid8 = 1'b0; rd_req8 = 1'b0; mem_rdata = '0;

    // Reset state
    cyc(); cyc();
    check("rst_fifo_level", fifo_level, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_rd_valid", rd_valid, 0);
    reset = 1'b0;
    cyc();
    check("wr_ready_after_reset", wr_ready, 1);

    // Single camera write reaches the bus two cycles later
    wr_valid = 1'b1; wr_addr = 20'h00010; wr_data = 16'hF800;
    cyc();
    wr_valid = 1'b0;
    check("wr1_level_after_push", fifo_level, 1);
    check("wr1_no_write_yet", mem_write, 0);
    cyc();
    check("wr1_mem_write", mem_write, 1);
    check("wr1_mem_address", mem_address, 20'h00010);
    check("wr1_mem_writedata", mem_writedata, 16'hF800);
    check("wr1_level_drained", fifo_level, 0);
    cyc();
    check("wr1_write_one_cycle", mem_write, 0);
    check("wr1_idle_address", mem_address, 0);

    // Single VGA read, data back 3 cycles after mem_read
    rd_req = 1'b1; rd_addr = 20'h12C00; mem_rdata = 16'hABCD;
    #1 check("rd1_rd_ready", rd_ready, 1);
    cyc();
    rd_req = 1'b0;
    check("rd1_mem_read", mem_read, 1);
    check("rd1_mem_address", mem_address, 20'h12C00);
    cyc();
    check("rd1_read_one_cycle", mem_read, 0);
    check("rd1_no_valid_c2", rd_valid, 0);
    cyc();
    check("rd1_no_valid_c3", rd_valid, 0);
    cyc();
    check("rd1_rd_valid", rd_valid, 1);
    check("rd1_rd_data", rd_data, 16'hABCD);
    cyc();
    check("rd1_valid_one_cycle", rd_valid, 0);

    // Starvation limit: 8 reads, 1 write, reads resume
    wr_valid = 1'b1; wr_addr = 20'h00020; wr_data = 16'h07E0;
    rd_req = 1'b1; rd_addr = 20'h00100;
    cyc();
    wr_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1 check("starve_read_grant", rd_ready, 1);
      check("starve_write_waiting", fifo_level, 1);
      cyc();
    end
    #1 check("starve_write_grant_rd_ready", rd_ready, 0);
    cyc();
    check("starve_mem_write", mem_write, 1);
    check("starve_mem_address", mem_address, 20'h00020);
    check("starve_mem_writedata", mem_writedata, 16'h07E0);
    #1 check("starve_reads_resume", rd_ready, 1);
    cyc();
    check("starve_mem_read_resumed", mem_read, 1);
    rd_req = 1'b0;
    repeat (6) cyc();

    // Buffer full and drop counting under constant read pressure
    rd_req = 1'b1; rd_addr = 20'h00200;
    wr_valid = 1'b1; wr_addr = 20'h00300; wr_data = 16'h001F;
    for (int i = 0; i < 6; i++) begin
      #1 check("full_wr_ready", wr_ready, (i < 4) ? 1 : 0);
      if (i == 4) check("full_level", fifo_level, 4);
      cyc();
    end
    check("full_drop_cnt_two", drop_cnt, 2);
    repeat (400) cyc();
    check("full_drop_cnt_saturated", drop_cnt, 255);
    wr_valid = 1'b0; rd_req = 1'b0;
    repeat (10) cyc();
    check("full_drained", fifo_level, 0);

    // Push and write grant together at level 4 (8-deep instance)
    rd_req8 = 1'b1;
    wr_valid8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_addr = 20'h00040 + 20'(i); wr_data = 16'h5500 + 16'(i);
      cyc();
    end
    rd_req8 = 1'b0;
    wr_addr = 20'h00044; wr_data = 16'h5504;
    #1 check("pp_level_before", fifo_level8, 4);
    check("pp_write_grant", rd_ready8, 0);
    check("pp_push_accepted", wr_ready8, 1);
    cyc();
    wr_valid8 = 1'b0;
    check("pp_level_held", fifo_level8, 4);
    check("pp_drop_unchanged", drop_cnt8, 0);
    check("pp_mem_write", mem_write8, 1);
    check("pp_mem_address", mem_address8, 20'h00040);

    // Mid-operation reset with 2 reads in flight and 3 buffered writes
    mem_rdata = 16'h1234;
    wr_valid = 1'b1; wr_addr = 20'h00500; wr_data = 16'h1111;
    cyc();
    rd_req = 1'b1; rd_addr = 20'h00600;
    cyc();
    cyc();
    rd_req = 1'b0; wr_valid = 1'b0; reset = 1'b1;
    check("mid_level_three", fifo_level, 3);
    check("mid_read_in_flight", mem_read, 1);
    cyc();
    reset = 1'b0;
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_mem_read", mem_read, 0);
    check("mid_rst_mem_write", mem_write, 0);
    check("mid_rst_mem_address", mem_address, 0);
    check("mid_rst_mem_writedata", mem_writedata, 0);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_drop_cnt", drop_cnt, 0);
    #1 check("mid_rst_wr_ready", wr_ready, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("mid_late_return_dropped", rd_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
